// File: rtl/wb_mem_responder_if.sv
// Wishbone-classic bus bundle between a core (master) and a memory responder (slave).
interface wb_mem_responder_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  sel_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        err_o;

  modport master (output cyc_i, stb_i, we_i, addr_i, data_i, sel_i,
                  input  data_o, ack_o, err_o);
  modport slave  (input  cyc_i, stb_i, we_i, addr_i, data_i, sel_i,
                  output data_o, ack_o, err_o);
endinterface

// File: rtl/wb_mem_responder.sv
// Wishbone-classic responder backed by a word-addressed RAM: configurable wait
// states, byte-lane writes, err termination for indices beyond MEM_DEPTH.
module wb_mem_responder #(
  parameter int    MEM_DEPTH   = 1024,
  parameter int    WAIT_CYCLES = 1,
  parameter string MEMORY_FILE = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [29:0] idx;
    logic [31:0] data;
    logic [3:0]  sel;
  } req_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  req_t          req_q, req_cur;
  logic [31:0]   mem [MEM_DEPTH];
  logic          bus_req, enter_resp, in_range;
  logic [AW-1:0] widx;
  logic          unused_addr_lsb;

  assign bus_req         = bus.cyc_i & bus.stb_i;
  assign unused_addr_lsb = ^bus.addr_i[1:0];

  // State register; the request is captured only on acceptance in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_WAIT) ? cnt + 4'd1 : 4'd0;
      if (state == S_IDLE && bus_req) req_q <= req_cur;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus_req) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (!bus.cyc_i)                            state_nxt = S_IDLE;
        else if (cnt == 4'(WAIT_CYCLES - 1))       state_nxt = S_RESP;
      end
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the request goes straight from the bus to RESP, so
  // the access uses the live bus fields rather than the latched copy.
  always_comb begin
    req_cur = req_q;
    if (state == S_IDLE) begin
      req_cur.we   = bus.we_i;
      req_cur.idx  = bus.addr_i[31:2];
      req_cur.data = bus.data_i;
      req_cur.sel  = bus.sel_i;
    end
    enter_resp = (state_nxt == S_RESP);
    in_range   = {2'b00, req_cur.idx} < 32'(MEM_DEPTH);
    widx       = req_cur.idx[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ack_o  <= 1'b0;
      bus.err_o  <= 1'b0;
      bus.data_o <= '0;
    end else begin
      bus.ack_o <= enter_resp & in_range;
      bus.err_o <= enter_resp & ~in_range;
      if (enter_resp) begin
        if (!in_range)        bus.data_o <= '0;
        else if (!req_cur.we) bus.data_o <= mem[widx];
      end
    end
  end

  // RAM is never reset; a write pending at reset is simply not committed.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && in_range && req_cur.we)
      for (int b = 0; b < 4; b++)
        if (req_cur.sel[b]) mem[widx][8*b +: 8] <= req_cur.data[8*b +: 8];
  end
endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (0, 1, 3 wait states) against a
// word/byte-level memory model with directed and randomized transactions.
module tb_wb_mem_responder;
  localparam int DEPTH   = 1024;
  localparam int KSTRIDE = 65536;

  logic clk, rst_n;
  logic        cyc [3], stb [3], we [3], ack [3], err [3];
  logic [31:0] addr [3], wdat [3], rdat [3];
  logic [3:0]  sel [3];

  int tests = 0;
  int fails = 0;
  logic [31:0] mdl [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_mem_responder_if bus ();
    wb_mem_responder #(
      .MEM_DEPTH(DEPTH), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.cyc_i  = cyc[g];
    assign bus.stb_i  = stb[g];
    assign bus.we_i   = we[g];
    assign bus.addr_i = addr[g];
    assign bus.data_i = wdat[g];
    assign bus.sel_i  = sel[g];
    assign ack[g]     = bus.ack_o;
    assign err[g]     = bus.err_o;
    assign rdat[g]    = bus.data_o;
  end

  function automatic int wc(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic c, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc[k] = c; stb[k] = c; we[k] = w; addr[k] = a; wdat[k] = d; sel[k] = s;
  endtask

  // Edges counted from the one that samples the request until ack/err is seen.
  task automatic wait_term(input int k, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ack[k] || err[k]) && n < 50);
    chk("ack_err_exclusive", 32'(ack[k] & err[k]), 32'd0);
  endtask

  task automatic model_write(input int key, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = mdl.exists(key) ? mdl[key] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mdl[key] = w;
  endtask

  task automatic xact(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int n, key;
    logic ak, er;
    logic [31:0] rd;
    bit inr;
    inr = (a >> 2) < DEPTH;
    key = k * KSTRIDE + int'(a[31:2] & 30'hFFFF);
    drive(k, 1'b1, w, a, d, s);
    wait_term(k, n);
    ak = ack[k]; er = err[k]; rd = rdat[k];
    drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("latency", 32'(n), 32'(wc(k) + 1));
    chk("ack", 32'(ak), 32'(inr));
    chk("err", 32'(er), 32'(!inr));
    if (!inr)    chk("err_data", rd, 32'h0);
    else if (!w) chk("rdata", rd, mdl[key]);
    else         model_write(key, d, s);
    @(posedge clk); #1;
    chk("no_back_to_back_term", 32'({ack[k], err[k]}), 32'd0);
  endtask

  initial begin
    int n, idx;
    int keys[$];
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset held with a live request: nothing may respond.
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_ack", 32'(ack[1]), 32'd0);
      chk("rst_err", 32'(err[1]), 32'd0);
      chk("rst_data", rdat[1], 32'h0);
    end
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack0", 32'(ack[0] | err[0]), 32'd0);

    // Single wait state: full-word write then read.
    xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    xact(1, 1'b0, 32'h10, 32'h0, 4'hF);
    chk("deadbeef_literal", mdl[1*KSTRIDE + 4], 32'hDEADBEEF);

    // Byte lanes and an empty select.
    xact(1, 1'b1, 32'h20, 32'h11223344, 4'hF);
    xact(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    xact(1, 1'b0, 32'h20, 32'h0, 4'hF);
    chk("lane_merge_literal", mdl[1*KSTRIDE + 8], 32'h11BB33DD);
    xact(1, 1'b1, 32'h20, 32'h99999999, 4'b0000);
    xact(1, 1'b0, 32'h20, 32'h0, 4'b0000);

    // Range boundary: last word acks, first word past the end errors.
    xact(1, 1'b1, 32'(4 * (DEPTH - 1)), 32'h0BADF00D, 4'hF);
    xact(1, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'hF);
    xact(1, 1'b0, 32'h1000, 32'h0, 4'hF);
    xact(1, 1'b1, 32'h1000, 32'h77777777, 4'hF);
    foreach (mdl[key]) if (key / KSTRIDE == 1) keys.push_back(key);
    foreach (keys[i]) xact(1, 1'b0, 32'((keys[i] % KSTRIDE) * 4), 32'h0, 4'hF);

    // Abort during the second of three wait cycles.
    xact(2, 1'b1, 32'h8, 32'h12345678, 4'hF);
    drive(2, 1'b1, 1'b1, 32'h8, 32'h55, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_no_term", 32'({ack[2], err[2]}), 32'd0);
    end
    xact(2, 1'b0, 32'h8, 32'h0, 4'hF);

    // Zero wait states, stb held across three reads.
    xact(0, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF);
    xact(0, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF);
    xact(0, 1'b1, 32'h8, 32'hC2C2C2C2, 4'hF);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      wait_term(0, n);
      chk("b2b_spacing", 32'(n), (i == 0) ? 32'd1 : 32'd2);
      chk("b2b_ack", 32'(ack[0]), 32'd1);
      chk("b2b_data", rdat[0], mdl[i]);
      if (i < 2) addr[0] = 32'((i + 1) * 4);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;

    // Randomized traffic on every instance, reads confined to written words.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) xact(k, 1'b1, 32'(i * 4), $urandom, 4'hF);
      repeat (25) begin
        idx = ($urandom_range(0, 7) == 0) ? DEPTH + int'($urandom_range(0, 3000))
                                          : int'($urandom_range(0, 15));
        xact(k, 1'($urandom_range(0, 1)), 32'(idx * 4) | 32'($urandom_range(0, 3)),
             $urandom, 4'($urandom_range(0, 15)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end
endmodule
